// File: rtl/char_ram_writer.sv
// rtl/char_ram_writer.sv - text-terminal write front end for the char RAM
module char_ram_writer #(
    parameter int          COLS   = 80,
    parameter int          ROWS   = 30,
    parameter int          ADDR_W = 12,
    parameter logic [7:0]  BLANK  = 8'h20
) (
    input  logic              clock100,
    input  logic              reset_n,
    input  logic [7:0]        char_in,
    input  logic              char_valid,
    output logic              char_ready,
    output logic [ADDR_W-1:0] ram_address,
    output logic [7:0]        ram_data,
    output logic              ram_wren,
    output logic [6:0]        cursor_col,
    output logic [4:0]        cursor_row,
    output logic              busy
);

    typedef enum logic [1:0] {IDLE, CLEAR_LINE, CLEAR_ALL} state_t;

    state_t            state, state_n;
    logic [6:0]        col, col_n;
    logic [4:0]        row, row_n;
    logic [ADDR_W-1:0] line_base, base_n;
    logic [ADDR_W-1:0] cnt, cnt_n;
    logic [ADDR_W-1:0] addr_n;
    logic [7:0]        data_n;
    logic              wren_n;

    logic              last_row;
    logic [4:0]        adv_row;
    logic [ADDR_W-1:0] adv_base;
    logic [ADDR_W-1:0] cur_addr;

    // line_base tracks row*COLS incrementally so no multiplier is needed
    assign last_row = (row == 5'(ROWS - 1));
    assign adv_row  = last_row ? '0 : row + 5'd1;
    assign adv_base = last_row ? '0 : line_base + ADDR_W'(COLS);
    assign cur_addr = line_base + ADDR_W'(col);

    assign char_ready = (state == IDLE) && reset_n;
    assign busy       = (state != IDLE);
    assign cursor_col = col;
    assign cursor_row = row;

    always_comb begin
        state_n = state;
        col_n   = col;
        row_n   = row;
        base_n  = line_base;
        cnt_n   = cnt;
        wren_n  = 1'b0;
        addr_n  = ram_address;
        data_n  = ram_data;
        case (state)
            IDLE: begin
                if (char_valid) begin
                    if (char_in >= 8'h20 && char_in <= 8'h7E) begin
                        wren_n = 1'b1;
                        addr_n = cur_addr;
                        data_n = char_in;
                        if (col == 7'(COLS - 1)) begin
                            col_n   = '0;
                            row_n   = adv_row;
                            base_n  = adv_base;
                            cnt_n   = '0;
                            state_n = CLEAR_LINE;
                        end else begin
                            col_n = col + 7'd1;
                        end
                    end else begin
                        case (char_in)
                            8'h0A: begin
                                col_n   = '0;
                                row_n   = adv_row;
                                base_n  = adv_base;
                                cnt_n   = '0;
                                state_n = CLEAR_LINE;
                            end
                            8'h0D: col_n = '0;
                            8'h08: begin
                                if (col != '0) begin
                                    col_n  = col - 7'd1;
                                    wren_n = 1'b1;
                                    addr_n = cur_addr - ADDR_W'(1);
                                    data_n = BLANK;
                                end
                            end
                            8'h0C: begin
                                col_n   = '0;
                                row_n   = '0;
                                base_n  = '0;
                                cnt_n   = '0;
                                state_n = CLEAR_ALL;
                            end
                            default: ;
                        endcase
                    end
                end
            end
            CLEAR_LINE: begin
                wren_n = 1'b1;
                addr_n = line_base + cnt;
                data_n = BLANK;
                if (cnt == ADDR_W'(COLS - 1)) begin
                    cnt_n   = '0;
                    state_n = IDLE;
                end else begin
                    cnt_n = cnt + ADDR_W'(1);
                end
            end
            CLEAR_ALL: begin
                wren_n = 1'b1;
                addr_n = cnt;
                data_n = BLANK;
                if (cnt == ADDR_W'(ROWS * COLS - 1)) begin
                    cnt_n   = '0;
                    col_n   = '0;
                    row_n   = '0;
                    base_n  = '0;
                    state_n = IDLE;
                end else begin
                    cnt_n = cnt + ADDR_W'(1);
                end
            end
            default: begin
                cnt_n   = '0;
                state_n = CLEAR_ALL;
            end
        endcase
    end

    always_ff @(posedge clock100 or negedge reset_n) begin
        if (!reset_n) begin
            state       <= CLEAR_ALL;
            col         <= '0;
            row         <= '0;
            line_base   <= '0;
            cnt         <= '0;
            ram_wren    <= 1'b0;
            ram_address <= '0;
            ram_data    <= '0;
        end else begin
            state       <= state_n;
            col         <= col_n;
            row         <= row_n;
            line_base   <= base_n;
            cnt         <= cnt_n;
            ram_wren    <= wren_n;
            ram_address <= addr_n;
            ram_data    <= data_n;
        end
    end

endmodule

// File: tb/tb_char_ram_writer.sv
// tb/tb_char_ram_writer.sv - directed self-checking bench for char_ram_writer
module tb_char_ram_writer;

    localparam int COLS   = 80;
    localparam int ROWS   = 30;
    localparam int ADDR_W = 12;

    logic              clock100 = 1'b0;
    logic              reset_n;
    logic [7:0]        char_in;
    logic              char_valid;
    logic              char_ready;
    logic [ADDR_W-1:0] ram_address;
    logic [7:0]        ram_data;
    logic              ram_wren;
    logic [6:0]        cursor_col;
    logic [4:0]        cursor_row;
    logic              busy;

    int checks = 0;
    int errors = 0;

    char_ram_writer #(.COLS(COLS), .ROWS(ROWS), .ADDR_W(ADDR_W), .BLANK(8'h20)) dut (
        .clock100    (clock100),
        .reset_n     (reset_n),
        .char_in     (char_in),
        .char_valid  (char_valid),
        .char_ready  (char_ready),
        .ram_address (ram_address),
        .ram_data    (ram_data),
        .ram_wren    (ram_wren),
        .cursor_col  (cursor_col),
        .cursor_row  (cursor_row),
        .busy        (busy)
    );

    always #5 clock100 = ~clock100;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // one-cycle byte; on return the resulting write (if any) is visible
    task automatic send(input logic [7:0] b);
        char_in    = b;
        char_valid = 1'b1;
        @(negedge clock100);
        char_valid = 1'b0;
    endtask

    task automatic wait_ready(input string tag, input int budget);
        for (int i = 0; i < budget && !char_ready; i++) @(negedge clock100);
        chk(tag, 32'(char_ready), 32'd1);
    endtask

    // entered on the cycle where the first blank write is visible
    task automatic clear_stream(input string tag, input int base, input int n);
        int good = 0;
        int ready_hi = 0;
        for (int i = 0; i < n; i++) begin
            if (ram_wren === 1'b1 && ram_address === ADDR_W'(base + i) && ram_data === 8'h20)
                good++;
            if (i < n - 1 && char_ready !== 1'b0) ready_hi++;
            @(negedge clock100);
        end
        chk({tag, "_writes"}, 32'(good), 32'(n));
        chk({tag, "_ready_low"}, 32'(ready_hi), 32'd0);
    endtask

    initial begin
        int good;
        reset_n    = 1'b0;
        char_in    = 8'h00;
        char_valid = 1'b0;
        #1;
        chk("rst_wren", 32'(ram_wren), 32'd0);
        chk("rst_addr", 32'(ram_address), 32'd0);
        chk("rst_data", 32'(ram_data), 32'd0);
        chk("rst_col", 32'(cursor_col), 32'd0);
        chk("rst_row", 32'(cursor_row), 32'd0);
        chk("rst_ready", 32'(char_ready), 32'd0);
        repeat (3) @(negedge clock100);
        reset_n = 1'b1;
        chk("rel_busy", 32'(busy), 32'd1);
        chk("rel_ready", 32'(char_ready), 32'd0);
        @(negedge clock100);
        clear_stream("boot_clear", 0, ROWS * COLS);
        chk("boot_end_wren", 32'(ram_wren), 32'd0);
        chk("boot_end_ready", 32'(char_ready), 32'd1);
        chk("boot_end_col", 32'(cursor_col), 32'd0);
        chk("boot_end_row", 32'(cursor_row), 32'd0);

        // "AB" back to back
        send(8'h41);
        chk("A_wren", 32'(ram_wren), 32'd1);
        chk("A_addr", 32'(ram_address), 32'd0);
        chk("A_data", 32'(ram_data), 32'h41);
        send(8'h42);
        chk("B_wren", 32'(ram_wren), 32'd1);
        chk("B_addr", 32'(ram_address), 32'd1);
        chk("B_data", 32'(ram_data), 32'h42);
        @(negedge clock100);
        chk("AB_idle_wren", 32'(ram_wren), 32'd0);
        chk("AB_col", 32'(cursor_col), 32'd2);

        // unknown control code is swallowed
        send(8'h01);
        chk("ctl01_wren", 32'(ram_wren), 32'd0);
        chk("ctl01_col", 32'(cursor_col), 32'd2);

        // full line from column 0 wraps into a line clear
        send(8'h0D);
        chk("cr_wren", 32'(ram_wren), 32'd0);
        chk("cr_col", 32'(cursor_col), 32'd0);
        good = 0;
        for (int i = 0; i < COLS; i++) begin
            send(8'h30 + 8'(i % 10));
            if (ram_wren === 1'b1 && ram_address === ADDR_W'(i) && ram_data === 8'h30 + 8'(i % 10))
                good++;
        end
        chk("line_writes", 32'(good), 32'(COLS));
        chk("line_last_addr", 32'(ram_address), 32'd79);
        chk("line_busy", 32'(busy), 32'd1);
        @(negedge clock100);
        clear_stream("wrap_clear", 80, COLS);
        chk("wrap_end_wren", 32'(ram_wren), 32'd0);
        chk("wrap_col", 32'(cursor_col), 32'd0);
        chk("wrap_row", 32'(cursor_row), 32'd1);

        // walk down to the last row, then LF wraps to row 0
        for (int r = 1; r < ROWS - 1; r++) begin
            send(8'h0A);
            wait_ready("lf_walk_ready", 200);
        end
        chk("row29", 32'(cursor_row), 32'd29);
        send(8'h0A);
        chk("lf29_no_write", 32'(ram_wren), 32'd0);
        chk("lf29_ready", 32'(char_ready), 32'd0);
        @(negedge clock100);
        clear_stream("lf29_clear", 0, COLS);
        chk("lf29_col", 32'(cursor_col), 32'd0);
        chk("lf29_row", 32'(cursor_row), 32'd0);

        // X, BS, BS
        send(8'h58);
        chk("X_addr", 32'(ram_address), 32'd0);
        chk("X_data", 32'(ram_data), 32'h58);
        send(8'h08);
        chk("bs1_wren", 32'(ram_wren), 32'd1);
        chk("bs1_addr", 32'(ram_address), 32'd0);
        chk("bs1_data", 32'(ram_data), 32'h20);
        chk("bs1_col", 32'(cursor_col), 32'd0);
        send(8'h08);
        chk("bs2_wren", 32'(ram_wren), 32'd0);
        chk("bs2_col", 32'(cursor_col), 32'd0);

        // move to (3,1), then FF with a byte held during the clear
        send(8'h0A);
        wait_ready("ff_setup_ready", 200);
        send(8'h51);
        chk("q_addr", 32'(ram_address), 32'd80);
        send(8'h52);
        send(8'h53);
        chk("pre_ff_col", 32'(cursor_col), 32'd3);
        chk("pre_ff_row", 32'(cursor_row), 32'd1);
        char_in    = 8'h0C;
        char_valid = 1'b1;
        @(negedge clock100);
        char_in = 8'h41;
        chk("ff_col", 32'(cursor_col), 32'd0);
        chk("ff_row", 32'(cursor_row), 32'd0);
        chk("ff_busy", 32'(busy), 32'd1);
        chk("ff_no_write", 32'(ram_wren), 32'd0);
        @(negedge clock100);
        clear_stream("ff_clear", 0, ROWS * COLS);
        chk("held_wren", 32'(ram_wren), 32'd1);
        chk("held_addr", 32'(ram_address), 32'd0);
        chk("held_data", 32'(ram_data), 32'h41);
        char_valid = 1'b0;
        @(negedge clock100);
        chk("held_no_dup", 32'(ram_wren), 32'd0);
        chk("held_col", 32'(cursor_col), 32'd1);

        // reset in the middle of a full clear
        send(8'h0C);
        @(negedge clock100);
        repeat (1000) @(negedge clock100);
        chk("mid_addr", 32'(ram_address), 32'd1000);
        chk("mid_wren", 32'(ram_wren), 32'd1);
        reset_n = 1'b0;
        #1;
        chk("async_wren", 32'(ram_wren), 32'd0);
        chk("async_addr", 32'(ram_address), 32'd0);
        repeat (2) @(negedge clock100);
        reset_n = 1'b1;
        @(negedge clock100);
        clear_stream("restart_clear", 0, ROWS * COLS);
        chk("restart_end_wren", 32'(ram_wren), 32'd0);
        chk("restart_ready", 32'(char_ready), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
